// File: rtl/lfsr_source.sv
// -----------------------------------------------------------------------------
// lfsr_source
//
// Responder end of the en_LFSR / complete_LFSR / LFSR_output request
// handshake. A maximal-length LFSR free-runs on every clock, so the value
// handed back depends on when the requester asks. On a request the block
// lets the LFSR advance WARMUP_STEPS times, captures the value and holds
// complete_LFSR high until en_LFSR is seen low.
//
// Handshake (4-phase, level based): the requester raises en_LFSR and keeps
// it high; complete_LFSR rises with LFSR_output valid and stays high until
// en_LFSR is sampled low; complete_LFSR then falls on the following edge.
// Dropping en_LFSR during the warm-up aborts the request without a capture.
//
// Ports:
//   clk            system clock, rising edge
//   rst_LFSR       synchronous active-low reset
//   en_LFSR        request level from the initiator
//   entropy_in     (LFSR_ENTROPY_EN only) extra bit mixed in while idle
//   complete_LFSR  captured value valid
//   LFSR_output    captured value, held after complete_LFSR falls
//   LFSR_busy      high while the warm-up is running
//
// Optional feature macro: LFSR_ENTROPY_EN
//   When defined, entropy_in is XORed into the feedback bit while idle.
// -----------------------------------------------------------------------------
module lfsr_source #(
  parameter int               WIDTH        = 7,
  parameter logic [WIDTH-1:0] TAPS         = 7'b1100000,
  parameter logic [WIDTH-1:0] SEED         = 7'h01,
  parameter int               WARMUP_STEPS = 13
) (
  input  logic             clk,
  input  logic             rst_LFSR,
  input  logic             en_LFSR,
`ifdef LFSR_ENTROPY_EN
  input  logic             entropy_in,
`endif
  output logic             complete_LFSR,
  output logic [WIDTH-1:0] LFSR_output,
  output logic             LFSR_busy
);

  // Counter only has to hold WARMUP_STEPS-1; keep at least one bit.
  localparam int CNT_W = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WARMUP_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] out_q;
  logic             complete_q;
  logic             busy_q;
  logic             fb;

  // Next LFSR value. The all-zero state is a lock-up; it is only reachable
  // through an upset (or entropy mixing), and SEED is reloaded instead so a
  // capture can never be zero.
  always_comb begin
    fb = ^(lfsr_q & TAPS);
`ifdef LFSR_ENTROPY_EN
    // Entropy only while idle, so warm-up timing stays deterministic.
    if (state_q == S_IDLE) begin
      fb = fb ^ entropy_in;
    end
`endif
    lfsr_d = {lfsr_q[WIDTH-2:0], fb};
    if ((lfsr_q == '0) || (lfsr_d == '0)) begin
      lfsr_d = SEED;
    end
  end

  // Free-running LFSR, advances in every state.
  always_ff @(posedge clk) begin
    if (!rst_LFSR) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Request FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_LFSR) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      out_q      <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_LFSR) begin
            state_q <= S_STEP;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_STEP: begin
          if (!en_LFSR) begin
            // Abort: no capture, previous output stays visible.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            // Capture the pre-edge value: WARMUP_STEPS advances after accept.
            out_q      <= lfsr_q;
            complete_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          // Stay here while en_LFSR is high; one capture per request.
          if (!en_LFSR) begin
            complete_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          complete_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign complete_LFSR = complete_q;
  assign LFSR_output   = out_q;
  assign LFSR_busy     = busy_q;

endmodule

// File: tb/tb_lfsr_source.sv
// -----------------------------------------------------------------------------
// tb_lfsr_source
//
// Directed bench for lfsr_source. A reference LFSR (x^7+x^6+1) is stepped
// alongside the clock; each accepted request pushes the value the reference
// predicts for the capture, which is popped when complete_LFSR rises.
// -----------------------------------------------------------------------------
module tb_lfsr_source;

  localparam int         WIDTH   = 7;
  localparam logic [6:0] SEED    = 7'h01;
  localparam int         WARMUP  = 13;
  localparam int         TIMEOUT = 40;
`ifdef LFSR_ENTROPY_EN
  localparam bit         ENT     = 1'b1;
`else
  localparam bit         ENT     = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_LFSR;
  logic             en_LFSR;
  logic             entropy_in;
  logic             complete_LFSR;
  logic [WIDTH-1:0] LFSR_output;
  logic             LFSR_busy;

  always #5 clk = ~clk;

  lfsr_source dut (
    .clk           (clk),
    .rst_LFSR      (rst_LFSR),
    .en_LFSR       (en_LFSR),
`ifdef LFSR_ENTROPY_EN
    .entropy_in    (entropy_in),
`endif
    .complete_LFSR (complete_LFSR),
    .LFSR_output   (LFSR_output),
    .LFSR_busy     (LFSR_busy)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] ref_lfsr;
  logic [WIDTH-1:0] last_out;
  logic [WIDTH-1:0] got;
  int               n_assert = 0;
  int               n_fail   = 0;

  function automatic logic [6:0] model_next(input logic [6:0] r, input logic rst_n,
                                            input logic e);
    logic [6:0] nxt;
    if (!rst_n)   return SEED;
    if (r == '0)  return SEED;
    nxt = {r[5:0], r[6] ^ r[5] ^ e};
    if (nxt == '0) return SEED;
    return nxt;
  endfunction

  function automatic logic [6:0] advance(input logic [6:0] r, input int n);
    logic [6:0] v;
    v = r;
    for (int k = 0; k < n; k++) v = model_next(v, 1'b1, 1'b0);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: reference steps at the edge, outputs sampled at the falling edge.
  // mix marks edges where the DUT is idle beforehand (entropy applies).
  task automatic step(input bit mix);
    @(posedge clk);
    ref_lfsr = model_next(ref_lfsr, rst_LFSR, mix & ENT & entropy_in);
    @(negedge clk);
  endtask

  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      entropy_in = ENT ? 1'($urandom_range(0, 1)) : 1'b0;
      step(1'b1);
      chk("idle_complete", complete_LFSR, 0);
    end
    entropy_in = 1'b0;
  endtask

  task automatic issue_and_wait(output logic [6:0] val);
    int n;
    en_LFSR = 1'b1;
    step(1'b1);
    exp_q.push_back(advance(ref_lfsr, WARMUP - 1));
    chk("busy_after_accept", LFSR_busy, 1);
    chk("complete_after_accept", complete_LFSR, 0);
    n = 0;
    while (!complete_LFSR && n < TIMEOUT) begin
      step(1'b0);
      n++;
    end
    chk("complete_latency", n, WARMUP);
    chk("capture_value", LFSR_output, exp_q.pop_front());
    chk("capture_nonzero", (LFSR_output != '0), 1);
    chk("busy_after_capture", LFSR_busy, 0);
    val = LFSR_output;
  endtask

  task automatic release_en(input logic [6:0] held);
    en_LFSR = 1'b0;
    step(1'b0);
    chk("complete_after_drop", complete_LFSR, 0);
    chk("output_held_after_drop", LFSR_output, held);
    chk("busy_after_drop", LFSR_busy, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_LFSR   = 1'b0;
    en_LFSR    = 1'b0;
    entropy_in = 1'b0;
    ref_lfsr   = '0;

    // Reset held 3 cycles, release with en_LFSR low.
    repeat (3) step(1'b0);
    chk("rst_complete", complete_LFSR, 0);
    chk("rst_output", LFSR_output, 0);
    chk("rst_busy", LFSR_busy, 0);
    rst_LFSR = 1'b1;
    idle_gap(2);
    chk("idle_output", LFSR_output, 0);
    chk("idle_busy", LFSR_busy, 0);

    // Reset again, request on the first edge after release: expect 0x42.
    rst_LFSR = 1'b0;
    repeat (3) step(1'b0);
    rst_LFSR = 1'b1;
    issue_and_wait(got);
    chk("first_capture_42", got, 7'h42);
    last_out = got;

    // Hold en_LFSR high: complete and value stay, no re-capture.
    for (int k = 0; k < 10; k++) begin
      step(1'b0);
      chk("hold_complete", complete_LFSR, 1);
      chk("hold_output", LFSR_output, 7'h42);
    end
    release_en(7'h42);

    // Abort after 5 cycles in the warm-up.
    en_LFSR = 1'b1;
    step(1'b1);
    chk("abort_busy", LFSR_busy, 1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0);
      chk("abort_no_complete", complete_LFSR, 0);
    end
    en_LFSR = 1'b0;
    step(1'b0);
    chk("abort_busy_clear", LFSR_busy, 0);
    chk("abort_output_kept", LFSR_output, last_out);
    idle_gap(3);
    chk("abort_output_still", LFSR_output, last_out);

    // Reset while in S_DONE, then same timing reproduces 0x42.
    issue_and_wait(got);
    rst_LFSR = 1'b0;
    step(1'b0);
    chk("rst_done_complete", complete_LFSR, 0);
    chk("rst_done_output", LFSR_output, 0);
    chk("rst_done_busy", LFSR_busy, 0);
    rst_LFSR = 1'b1;
    issue_and_wait(got);
    chk("repro_capture_42", got, 7'h42);
    release_en(got);

    // Back-to-back requests with varying idle gaps.
    for (int i = 0; i < 127; i++) begin
      idle_gap($urandom_range(0, 5));
      issue_and_wait(got);
      release_en(got);
    end

    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
